// File: rtl/activation_pkg.sv
// rtl/activation_pkg.sv - shared mode encoding and clamp ceiling helper for activation_stream
package activation_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10,
        ACT_CLAMP  = 2'b11
    } act_mode_e;

    // 6.0 in fixed point, saturated to the largest positive lane value when it does not fit
    function automatic longint act_ceil(input int precision, input int frac_bits);
        longint max_pos;
        longint ceil_val;
        max_pos = (longint'(1) << (precision - 1)) - longint'(1);
        if (frac_bits >= 60) begin
            return max_pos;
        end
        ceil_val = longint'(6) << frac_bits;
        return (ceil_val > max_pos) ? max_pos : ceil_val;
    endfunction

endpackage

// File: rtl/act_lane.sv
// rtl/act_lane.sv - combinational activation function for one signed fixed-point lane
module act_lane
    import activation_pkg::*;
#(
    parameter int PRECISION  = 16,
    parameter int FRAC_BITS  = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  act_mode_e                    mode,
    input  logic signed [PRECISION-1:0]  lane_in,
    output logic signed [PRECISION-1:0]  lane_out
);

    localparam longint CEIL_L = act_ceil(PRECISION, FRAC_BITS);
    localparam logic signed [PRECISION-1:0] CEIL = CEIL_L[PRECISION-1:0];

    logic is_neg;
    logic is_zero;

    assign is_neg  = lane_in[PRECISION-1];
    assign is_zero = (lane_in == '0);

    always_comb begin
        lane_out = lane_in;
        case (mode)
            ACT_BYPASS: lane_out = lane_in;
            ACT_RELU:   lane_out = (is_neg || is_zero) ? '0 : lane_in;
            // arithmetic shift floors toward -inf, so -1 stays -1
            ACT_LEAKY:  lane_out = is_neg ? (lane_in >>> LEAK_SHIFT) : lane_in;
            ACT_CLAMP: begin
                if (is_neg || is_zero) begin
                    lane_out = '0;
                end else if (lane_in >= CEIL) begin
                    lane_out = CEIL;
                end else begin
                    lane_out = lane_in;
                end
            end
            default:    lane_out = lane_in;
        endcase
    end

endmodule

// File: rtl/activation_stream.sv
// rtl/activation_stream.sv - two-stage valid/ready activation pipeline; ACTIVATION_STREAM_STATS_EN adds zero_count
module activation_stream
    import activation_pkg::*;
#(
    parameter int PRECISION  = 16,
    parameter int LANES      = 4,
    parameter int FRAC_BITS  = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*PRECISION-1:0]   in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*PRECISION-1:0]   out_data,
    output logic                         out_last
`ifdef ACTIVATION_STREAM_STATS_EN
    ,
    output logic [31:0]                  zero_count
`endif
);

    localparam int W = LANES * PRECISION;

    logic         s1_valid;
    logic [W-1:0] s1_data;
    act_mode_e    s1_mode;
    logic         s1_last;
    logic         s2_valid;
    logic [W-1:0] s2_data;
    logic         s2_last;
    logic [W-1:0] lane_result;
    logic         s1_adv;

    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_last  = s2_last;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        act_lane #(
            .PRECISION (PRECISION),
            .FRAC_BITS (FRAC_BITS),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .mode    (s1_mode),
            .lane_in (s1_data[k*PRECISION +: PRECISION]),
            .lane_out(lane_result[k*PRECISION +: PRECISION])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= ACT_BYPASS;
            s1_last  <= 1'b0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= lane_result;
                    s2_last <= s1_last;
                end
            end
            // mode and last travel with the beat so later mode changes never touch it
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_mode <= act_mode_e'(mode);
                    s1_last <= in_last;
                end
            end
        end
    end

`ifdef ACTIVATION_STREAM_STATS_EN
    logic [31:0] zero_lanes;
    logic [32:0] zero_sum;

    always_comb begin
        zero_lanes = '0;
        for (int k = 0; k < LANES; k++) begin
            if (s2_data[k*PRECISION +: PRECISION] == '0) begin
                zero_lanes = zero_lanes + 32'd1;
            end
        end
        zero_sum = {1'b0, zero_count} + {1'b0, zero_lanes};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_count <= '0;
        end else if (out_valid && out_ready) begin
            zero_count <= zero_sum[32] ? '1 : zero_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_activation_stream.sv
// tb/tb_activation_stream.sv - directed self-checking bench for activation_stream
module tb_activation_stream;
    import activation_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
`ifdef ACTIVATION_STREAM_STATS_EN
    logic [31:0] zero_count;
`endif

    act_mode_e   lane14_mode;
    logic [15:0] lane14_in;
    logic [15:0] lane14_out;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_zc   = 0;

    always #5 clk = ~clk;

    activation_stream dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef ACTIVATION_STREAM_STATS_EN
        ,
        .zero_count(zero_count)
`endif
    );

    act_lane #(.PRECISION(16), .FRAC_BITS(14), .LEAK_SHIFT(3)) u_lane14 (
        .mode    (lane14_mode),
        .lane_in (lane14_in),
        .lane_out(lane14_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic logic [63:0] beat(input int i);
        return pack4(i + 1, 100 + i, 200 + i, -(i + 1));
    endfunction

    task automatic check_zc(input string tag);
`ifdef ACTIVATION_STREAM_STATS_EN
        check(tag, zero_count, exp_zc);
`else
        n_checks = n_checks + 0;
        if (tag.len() == 0) $display("empty tag");
`endif
    endtask

    task automatic vec(input string tag, input logic [1:0] m, input logic [63:0] d,
                       input logic [63:0] exp, input int zeros);
        mode = m; in_data = d; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp);
        exp_zc += zeros;
        @(posedge clk); #1;
        check({tag, "_drain"}, out_valid, 0);
        check_zc({tag, "_zc"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got;
        logic stall_prev;
        logic [63:0] held_d;
        logic held_l;

        rst = 1'b1; mode = 2'b00; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        lane14_mode = ACT_CLAMP; lane14_in = 16'h4000;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check_zc("rst_zc");

        vec("relu",   2'b01, pack4(5, -3, 0, 32767), pack4(5, 0, 0, 32767), 2);
        vec("bypass", 2'b00, pack4(-7, 0, 123, -32768), pack4(-7, 0, 123, -32768), 1);
        vec("leaky",  2'b10, pack4(-8, -1, -32768, 100), pack4(-1, -1, -4096, 100), 0);
        vec("clamp",  2'b11, pack4(16'h0700, 16'h0500, -2, 16'h0600), pack4(16'h0600, 16'h0500, 0, 16'h0600), 1);
        vec("leaky2", 2'b10, pack4(-9, 7, -16, 0), pack4(-2, 7, -2, 0), 1);
        vec("clamp2", 2'b11, pack4(16'h05FF, 1, -32768, 16'h7FFF), pack4(16'h05FF, 1, 0, 16'h0600), 1);

        check("ceil14_mid", lane14_out, 16'h4000);
        lane14_in = 16'h7FFF; #1;
        check("ceil14_max", lane14_out, 16'h7FFF);
        lane14_in = 16'h7000; #1;
        check("ceil14_hi", lane14_out, 16'h7000);

        // mode switch under backpressure
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00; in_data = pack4(-5, 3, -1, 0);
        @(posedge clk); #1;
        mode = 2'b01; in_data = pack4(-5, 3, -1, 0);
        check("ms_ready1", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ms_valid", out_valid, 1);
        check("ms_beat1", out_data, pack4(-5, 3, -1, 0));
        check("ms_full", in_ready, 0);
        @(posedge clk); #1;
        check("ms_hold", out_data, pack4(-5, 3, -1, 0));
        check("ms_full2", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_zc += 1;
        check("ms_beat2", out_data, pack4(0, 3, 0, 0));
        check("ms_ready2", in_ready, 1);
        @(posedge clk); #1;
        exp_zc += 3;
        check("ms_drain", out_valid, 0);
        check_zc("ms_zc");

        // ten-beat stream with random backpressure
        mode = 2'b00; sent = 0; got = 0; stall_prev = 1'b0; held_d = '0; held_l = 1'b0;
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 10);
            in_data   = beat(sent);
            in_last   = (sent == 9);
            @(negedge clk);
            if (stall_prev) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, held_d);
                check("stall_last", out_last, held_l);
            end
            if (out_valid && out_ready) begin
                check("stream_data", out_data, beat(got));
                check("stream_last", out_last, (got == 9));
                got++;
            end
            stall_prev = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        check("stream_count", got, 10);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("stream_drain", out_valid, 0);
        check_zc("stream_zc");

        // reset with both stages full, racing an accept and a drain
        out_ready = 1'b0; in_valid = 1'b1; mode = 2'b01; in_data = pack4(1, 2, 3, 4); in_last = 1'b1;
        @(posedge clk); #1;
        in_data = pack4(5, 6, 7, 8); in_last = 1'b0;
        @(posedge clk); #1;
        check("full_valid", out_valid, 1);
        check("full_last", out_last, 1);
        check("full_ready", in_ready, 0);
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_zc = 0;
        check("rst2_valid", out_valid, 0);
        check("rst2_data", out_data, 0);
        check("rst2_last", out_last, 0);
        check("rst2_ready", in_ready, 1);
        check_zc("rst2_zc");
        @(posedge clk); #1;
        check("rst2_empty", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
